// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD datapath family (adder, subtractor
// and later BCD blocks). Holds the digit limit, the common controller state
// encoding and the default operand size.
package bcd_pkg;

  // Largest legal value of a single 8421-BCD digit.
  localparam int BCD_DIGIT_MAX = 9;

  // Default number of BCD digits per operand.
  localparam int BCD_DEFAULT_DIGITS = 8;

  // Controller states shared by the digit-serial BCD blocks.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } bcd_state_e;

  // True when a 4-bit code is not a legal BCD digit (10..15).
  function automatic logic bcd_digit_bad(input logic [3:0] digit);
    return (digit > 4'(BCD_DIGIT_MAX));
  endfunction

endpackage

// File: rtl/bcd_sub8421_if.sv
// Start/ready request interface of the serial BCD subtractor. The same
// signal set drives the serial BCD adder, so one controller can talk to
// either block. The master issues operands, the slave returns the result.
interface bcd_sub8421_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = BCD_DEFAULT_DIGITS
) ();

  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic [4*DIGITS-1:0]   c;
  logic                  neg;
  logic                  err;
  logic                  ready;
  logic                  busy;

  modport master (
    output start,
    output a,
    output b,
    input  c,
    input  neg,
    input  err,
    input  ready,
    input  busy
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output c,
    output neg,
    output err,
    output ready,
    output busy
  );

endinterface

// File: rtl/bcd_digit_sub.sv
// One-digit BCD subtract cell: diff = x - y - bin, folded back into 0..9
// with a borrow out. Also flags operand digits that are not legal BCD.
// Purely combinational; the subtractor shares a single instance between
// its subtract pass and its ten's-complement pass.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout,
  output logic       bad
);

  logic [4:0] d_raw;
  logic [4:0] d_adj;

  // 5-bit two's complement difference; a negative result borrows ten from
  // the next digit. Range is -16..15, so bit 4 is the sign.
  always_comb begin
    d_raw = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
    d_adj = d_raw;
    bout  = 1'b0;
    if (d_raw[4]) begin
      d_adj = d_raw + 5'd10;
      bout  = 1'b1;
    end
    diff = d_adj[3:0];
    bad  = bcd_digit_bad(x) || bcd_digit_bad(y);
  end

endmodule

// File: rtl/bcd_sub8421.sv
// Digit-serial 8421-BCD subtractor. Computes |a-b| as packed BCD plus a
// sign flag, one digit per clock. A negative raw result (final borrow out
// of the subtract pass) is turned into its magnitude by a second pass that
// subtracts the raw result from zero, i.e. takes its ten's complement.
// ready pulses for one cycle in the first idle cycle after the result is
// complete; c, neg and err then hold until the next accepted start.
module bcd_sub8421
  import bcd_pkg::*;
#(
  parameter int DIGITS = BCD_DEFAULT_DIGITS
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_sub8421_if.slave       bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

  bcd_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           borrow_q, borrow_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   c_q, c_d;
  logic           neg_q, neg_d;
  logic           err_q, err_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;

  logic [3:0]     x_sel;
  logic [3:0]     y_sel;
  logic [3:0]     dig_diff;
  logic           dig_bout;
  logic           dig_bad;

  // Operand mux for the shared digit cell: a_i - b_i while subtracting,
  // 0 - c_i while complementing a negative raw result.
  always_comb begin
    x_sel = 4'd0;
    y_sel = c_q[cnt_q * 4 +: 4];
    if (state_q == SUB) begin
      x_sel = a_q[cnt_q * 4 +: 4];
      y_sel = b_q[cnt_q * 4 +: 4];
    end
  end

  bcd_digit_sub u_digit (
    .x    (x_sel),
    .y    (y_sel),
    .bin  (borrow_q),
    .diff (dig_diff),
    .bout (dig_bout),
    .bad  (dig_bad)
  );

  // Controller and datapath next-state: latch operands on start, walk the
  // digits LSD first, optionally run the complement pass, then report.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    neg_d    = neg_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          cnt_d    = '0;
          borrow_d = 1'b0;
          err_d    = 1'b0;
          state_d  = SUB;
        end
      end

      SUB: begin
        c_d[cnt_q * 4 +: 4] = dig_diff;
        borrow_d            = dig_bout;
        err_d               = err_q | dig_bad;
        if (cnt_q == LAST_DIGIT) begin
          cnt_d = '0;
          if (dig_bout) begin
            neg_d    = 1'b1;
            borrow_d = 1'b0;
            state_d  = FIX;
          end else begin
            neg_d   = 1'b0;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      FIX: begin
        c_d[cnt_q * 4 +: 4] = dig_diff;
        borrow_d            = dig_bout;
        if (cnt_q == LAST_DIGIT) begin
          cnt_d    = '0;
          borrow_d = 1'b0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered status flags: busy covers the operation from the first digit
  // edge up to the edge leaving DONE; ready pulses in the idle cycle that
  // follows DONE, when c/neg/err are final and a new start can be taken.
  always_comb begin
    busy_d  = (state_q != IDLE) && (state_d != IDLE);
    ready_d = (state_q == DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.c     = c_q;
  assign bus.neg   = neg_q;
  assign bus.err   = err_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;

endmodule
